display_scan_ctrl: RTL and testbench

Scan scheduler for the 8-digit multiplexed seven-segment display. Holds a tear-free 32-bit display word, time-slices the shared nibble→segment path across the eight digits with a programmable refresh rate and anti-ghosting dead time, and drives the active-low anodes. Sits between the value producers and the `bcd_to_7` decoder, replacing the free-running counter/mux/decoder chain in the display datapath.

---
 rtl/display_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Scan scheduler for an 8-digit multiplexed seven-segment display.  Holds a
// tear-free 32-bit display word, time-slices the shared nibble path across the
// eight digits and drives active-low anodes with a blanked dead time at the
// start of every digit slot.
//
// Parameters
//   TICK_DIV     clock cycles per digit slot (>= 4)
//   DEAD_CYCLES  blanked cycles at the start of each slot (1 .. TICK_DIV-1)
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   data_in      display word, nibble i -> digit i (digit 0 rightmost)
//   load         capture data_in into the pending word
//   digit_en     per-digit enable, 0 keeps the digit dark
//   lz_blank     enable leading-zero blanking
//   nibble       nibble of the current digit (to bcd_to_7)
//   digit_idx    index of the current slot
//   anodes       active-low anode drive
//   pending      a loaded word waits for the next frame boundary
//   frame_start  one-cycle pulse on the first cycle of the digit-0 slot
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_START | first cycle out of reset; scan position held at digit 0/cnt 0
//   ST_BLANK | dead time at the start of a slot, all anodes off
//   ST_SHOW  | remainder of the slot, current digit may be lit
//
// The registers cnt/digit_idx/state describe the position whose outputs are
// currently visible.  The outputs are computed from the *next* position, so
// nibble/anodes/frame_start are registered and still line up with digit_idx.
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int TICK_DIV    = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  nibble,
  output logic [2:0]  digit_idx,
  output logic [7:0]  anodes,
  output logic        pending,
  output logic        frame_start
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       idx_nxt;
  logic [31:0]      disp_word;
  logic [31:0]      pend_word;
  logic [31:0]      word_nxt;
  logic             at_boundary;
  logic             transfer;
  logic [7:0]       lz_dark;
  logic             hi_zero;
  logic             lit_nxt;
  logic [3:0]       nibble_nxt;
  logic [7:0]       anodes_nxt;
  logic             frame_nxt;

  // ---------------------------------------------------------------------------
  // Next scan position and the outputs that belong to it
  // ---------------------------------------------------------------------------
  always_comb begin
    at_boundary = 1'b0;
    cnt_nxt     = cnt;
    idx_nxt     = digit_idx;
    state_nxt   = state;

    case (state)
      ST_START: begin
        // Hold at digit 0 / cnt 0 so the first visible cycle is the frame start.
        cnt_nxt   = '0;
        idx_nxt   = 3'd0;
        state_nxt = ST_BLANK;
      end
      ST_BLANK: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == DEAD_LAST) begin
          state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt     = '0;
          idx_nxt     = digit_idx + 3'd1;
          state_nxt   = ST_BLANK;
          at_boundary = (digit_idx == 3'd7);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        idx_nxt   = 3'd0;
        state_nxt = ST_BLANK;
      end
    endcase

    transfer = at_boundary && pending;

    // Bypass so the first digit of a new frame already shows the new word.
    word_nxt = transfer ? pend_word : disp_word;

    nibble_nxt = word_nxt[{idx_nxt, 2'b00} +: 4];

    // Walk from the top digit down: a digit is dark when it and every digit
    // above it hold zero.  Digit 0 always stays visible.
    hi_zero = 1'b1;
    lz_dark = '0;
    for (int i = 7; i >= 0; i--) begin
      hi_zero    = hi_zero && (word_nxt[4*i +: 4] == 4'h0);
      lz_dark[i] = (i != 0) && hi_zero;
    end

    lit_nxt = (state_nxt == ST_SHOW) && digit_en[idx_nxt] &&
              !(lz_blank && lz_dark[idx_nxt]);

    anodes_nxt = lit_nxt ? ~(8'b1 << idx_nxt) : 8'hFF;
    frame_nxt  = (cnt_nxt == '0) && (idx_nxt == 3'd0);
  end

  // ---------------------------------------------------------------------------
  // State, word registers and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_START;
      cnt         <= '0;
      digit_idx   <= 3'd0;
      disp_word   <= '0;
      pend_word   <= '0;
      pending     <= 1'b0;
      nibble      <= 4'h0;
      anodes      <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      digit_idx <= idx_nxt;

      if (transfer) begin
        disp_word <= pend_word;
      end

      // A load on the boundary cycle re-arms pending for the following frame;
      // the transfer above still uses the pending word from before this cycle.
      if (load) begin
        pend_word <= data_in;
        pending   <= 1'b1;
      end else if (at_boundary) begin
        pending <= 1'b0;
      end

      nibble      <= nibble_nxt;
      anodes      <= anodes_nxt;
      frame_start <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  localparam int TD    = 8;
  localparam int DC    = 2;
  localparam int FRAME = 8 * TD;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  nibble;
  logic [2:0]  digit_idx;
  logic [7:0]  anodes;
  logic        pending;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  // reference model: scan position as a plain count within the frame
  bit          m_valid   = 1'b0;
  logic [31:0] m_disp    = '0;
  logic [31:0] m_pend    = '0;
  bit          m_pending = 1'b0;
  int          m_pos     = 0;
  logic [7:0]  m_en      = 8'hFF;
  bit          m_lz      = 1'b0;

  logic [31:0] a_word;
  logic [31:0] b_word;

  display_scan_ctrl #(.TICK_DIV(TD), .DEAD_CYCLES(DC)) dut (
    .clock      (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load       (load),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .nibble     (nibble),
    .digit_idx  (digit_idx),
    .anodes     (anodes),
    .pending    (pending),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [7:0]  e_an;
    logic [3:0]  e_nib;
    logic [2:0]  e_idx;
    logic        e_fs;
    int          d;
    int          c;
    bit          dark;
    bit          lit;
    logic [31:0] hi;
    if (!m_valid) begin
      e_an  = 8'hFF;
      e_nib = 4'h0;
      e_idx = 3'd0;
      e_fs  = 1'b0;
    end else begin
      d     = m_pos / TD;
      c     = m_pos % TD;
      hi    = m_disp >> (4 * d);
      e_nib = hi[3:0];
      dark  = m_lz && (d > 0) && (hi == 32'd0);
      lit   = (c >= DC) && m_en[d] && !dark;
      e_an  = lit ? (8'hFF & ~(8'h01 << d)) : 8'hFF;
      e_idx = 3'(d);
      e_fs  = (m_pos == 0);
    end
    check("anodes", {24'd0, anodes}, {24'd0, e_an});
    check("nibble", {28'd0, nibble}, {28'd0, e_nib});
    check("digit_idx", {29'd0, digit_idx}, {29'd0, e_idx});
    check("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
    check("pending", {31'd0, pending}, {31'd0, m_pending});
  endtask

  // one clock: advance the model with the inputs seen at the edge, then check
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_valid   = 1'b0;
      m_disp    = '0;
      m_pend    = '0;
      m_pending = 1'b0;
      m_pos     = 0;
    end else begin
      if (!m_valid) begin
        m_valid = 1'b1;
        m_pos   = 0;
      end else begin
        if (m_pos == FRAME - 1 && m_pending) begin
          m_disp    = m_pend;
          m_pending = 1'b0;
        end
        m_pos = (m_pos + 1) % FRAME;
      end
      if (load) begin
        m_pend    = data_in;
        m_pending = 1'b1;
      end
    end
    m_en = digit_en;
    m_lz = lz_blank;
    #1;
    check_all();
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (m_pos != target && n < 3 * FRAME);
    if (m_pos != target) begin
      bad++;
      $display("FAIL run_to observed_pos=%0d required_pos=%0d", m_pos, target);
    end
  endtask

  task automatic pulse_load(input logic [31:0] w);
    data_in = w;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    data_in  = '0;
    digit_en = 8'hFF;
    lz_blank = 1'b0;

    // scan after reset
    repeat (3) step();
    check("reset_anodes", {24'd0, anodes}, 32'hFF);
    reset = 1'b0;
    pulse_load(32'h76543210);
    check("first_frame_start", {31'd0, frame_start}, 32'd1);
    check("pending_after_load", {31'd0, pending}, 32'd1);
    run_to(FRAME - 1);
    check("pending_at_boundary", {31'd0, pending}, 32'd1);
    step();
    check("pending_cleared", {31'd0, pending}, 32'd0);
    repeat (TD + DC) step();
    check("digit1_lit", {24'd0, anodes}, 32'hFD);
    check("digit1_nibble", {28'd0, nibble}, 32'd1);
    repeat (FRAME) step();

    // leading-zero blanking
    lz_blank = 1'b1;
    pulse_load(32'h0000_0A05);
    repeat (2 * FRAME) step();
    pulse_load(32'h0000_0000);
    repeat (2 * FRAME) step();

    // digit enable
    lz_blank = 1'b0;
    digit_en = 8'b0000_0101;
    pulse_load($urandom | 32'h1000_0000);
    repeat (2 * FRAME) step();

    // no tearing
    digit_en = 8'hFF;
    pulse_load(32'h1111_1111);
    run_to(0);
    run_to(3 * TD + 3);
    pulse_load(32'h2222_2222);
    run_to(0);
    check("no_tear_new", {28'd0, nibble}, 32'd2);
    repeat (FRAME) step();

    // boundary collision
    a_word = $urandom;
    b_word = ~a_word;
    run_to(20);
    pulse_load(a_word);
    run_to(FRAME - 1);
    data_in = b_word;
    load    = 1'b1;
    step();
    load    = 1'b0;
    check("collision_shows_a", {28'd0, nibble}, {28'd0, a_word[3:0]});
    check("collision_pending", {31'd0, pending}, 32'd1);
    run_to(0);
    check("collision_shows_b", {28'd0, nibble}, {28'd0, b_word[3:0]});
    check("collision_pending_clr", {31'd0, pending}, 32'd0);

    // random traffic
    repeat (6 * FRAME) begin
      if ($urandom_range(0, 9) == 0) begin
        data_in = $urandom >> (4 * $urandom_range(0, 8));
        load    = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) digit_en = 8'($urandom);
      if ($urandom_range(0, 31) == 0) lz_blank = 1'($urandom_range(0, 1));
      step();
    end
    load     = 1'b0;
    digit_en = 8'hFF;
    lz_blank = 1'b0;
    pulse_load(32'h89AB_CDEF);
    repeat (2 * FRAME) step();

    // mid-frame reset with a colliding load that must be dropped
    run_to(5 * TD + 4);
    reset   = 1'b1;
    data_in = 32'hDEAD_BEEF;
    load    = 1'b1;
    step();
    load    = 1'b0;
    check("rst_anodes", {24'd0, anodes}, 32'hFF);
    check("rst_pending", {31'd0, pending}, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("rst_frame_start", {31'd0, frame_start}, 32'd1);
    repeat (2 * FRAME) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
